// File: rtl/bus_arbiter8.sv
// Eight-way round-robin bus arbiter with a per-grant hold limit and a forced
// zero-grant gap cycle between any two grants.
//
// state | meaning
// IDLE  | no grant; arbitrate when en=1 and any req is set
// GRANT | one requester owns the bus; hcnt counts cycles held
// GAP   | grant just dropped; one zero cycle, arbitrate again if possible
module bus_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] last;
    logic [7:0] hcnt;
    logic [2:0] win;
    logic [2:0] cand;
    logic       found;

    // Search starts just past the previous winner, so it is considered last.
    always_comb begin
        win   = last;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= 8; i++) begin
            cand = last + 3'(i);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hcnt      <= '0;
            last      <= 3'd7;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (en && found) begin
                        gnt       <= 8'b1 << win;
                        gnt_idx   <= win;
                        last      <= win;
                        hcnt      <= 8'd1;
                        gnt_valid <= 1'b1;
                        state     <= GRANT;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (!en) begin
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (!req[gnt_idx]) begin
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        state     <= GAP;
                    end else if (hcnt == 8'(MAX_HOLD)) begin
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        timeout   <= 1'b1;
                        state     <= GAP;
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                default: begin
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bus_arbiter8.md
BUS_ARBITER8 -- requirements
Module: bus_arbiter8

Interface
REQ-001 SHALL provide parameter MAX_HOLD, default 16, giving the maximum consecutive grant cycles per requester; legal range 2..255.
REQ-002 SHALL provide port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL provide port en, input, 1 bit: arbitration enable.
REQ-005 SHALL provide port req, input, 8 bits: one request line per requester; bit i corresponds to requester i.
REQ-006 SHALL provide port gnt, output, 8 bits: one-hot grant, registered, to drive shared-bus enables.
REQ-007 SHALL provide port gnt_idx, output, 3 bits: binary index of the current or most recent grant, registered.
REQ-008 SHALL provide port gnt_valid, output, 1 bit: high exactly when gnt is nonzero.
REQ-009 SHALL provide port timeout, output, 1 bit: one-cycle pulse when a grant is revoked on reaching MAX_HOLD.

Function
REQ-010 SHALL implement states IDLE, GRANT and GAP, with a 3-bit last-winner pointer `last` and an 8-bit hold counter `hcnt`.
REQ-011 SHALL, in IDLE or GAP with en=1 and req!=0, select the first set req bit searching from (last+1) mod 8 upward with wrap 7->0, then enter GRANT.
REQ-012 SHALL, on that selection edge, register gnt = one-hot(winner), gnt_idx = winner, last = winner and hcnt = 1; latency is one edge from sampled req to visible gnt.
REQ-013 SHALL, in GAP with en=0 or req=0, enter IDLE; IDLE with en=0 or req=0 SHALL remain IDLE.
REQ-014 SHALL, in GRANT, hold gnt unchanged and increment hcnt each cycle while req[gnt_idx]=1, en=1 and hcnt<MAX_HOLD.
REQ-015 SHALL, in GRANT when req[gnt_idx]=0, clear gnt on the next edge and enter GAP, with no timeout.
REQ-016 SHALL, in GRANT when hcnt=MAX_HOLD and req[gnt_idx]=1, clear gnt, pulse timeout high for exactly that following cycle and enter GAP.
REQ-017 SHALL, in GRANT when en=0, clear gnt on the next edge and enter IDLE, with no timeout; en=0 takes precedence over REQ-015 and REQ-016.
REQ-018 SHALL keep gnt all-zero in IDLE and GAP, so any two grants are separated by at least one zero cycle.
REQ-019 SHALL keep gnt_idx and last holding the most recent winner while gnt_valid=0.
REQ-020 SHALL ignore changes on req bits other than gnt_idx while in GRANT, so no preemption occurs.
REQ-021 SHALL make the winner of REQ-011 eligible again only after all other asserted requesters, giving round-robin fairness.
REQ-022 SHALL allow a sole requester that timed out to be regranted after the one GAP cycle.
REQ-023 SHALL always drive gnt as all-zero or exactly one bit, never multi-hot.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, hcnt=0 and last=7, so requester 0 has first priority.
REQ-025 SHALL, on rst_n assertion mid-grant, drop gnt immediately without waiting for a clock edge; the first arbitration occurs on the first rising edge after rst_n deasserts.

Verification
REQ-026 SHALL cover: reset, en=1, req=8'h05 -> after one edge gnt=8'h01, gnt_idx=0, gnt_valid=1.
REQ-027 SHALL cover: continuing REQ-026, drop req[0] -> next cycle gnt=0 (GAP); the following cycle gnt=8'h04, gnt_idx=2.
REQ-028 SHALL cover: MAX_HOLD=4, req=8'hFF held -> each grant lasts 4 cycles, timeout pulses after each, one zero gap cycle, grant order 0,1,...,7,0.
REQ-029 SHALL cover: MAX_HOLD=3, req=8'h80 held -> gnt=8'h80 for 3 cycles, timeout=1 with gnt=0 for 1 cycle, then gnt=8'h80 again.
REQ-030 SHALL cover: en falls during grant to requester 3 -> next cycle gnt=0, state IDLE, timeout=0; en=1 with req=8'h09 -> grant to requester 0 (search starts at index 4 and wraps).
REQ-031 SHALL cover: rst_n pulsed low mid-grant between clock edges -> gnt=0 immediately; after release, req=8'h81 -> grant to requester 0.
